// File: rtl/ysyx_22050710_lsu_req_queue.sv
// LSU request queue: buffers EX memory requests, issues them in order on an SRAM-like
// req/addr_ok/data_ok bus, and returns in-order responses (including misalign errors) to MS.
module ysyx_22050710_lsu_req_queue #(
    parameter int ADDR_WD   = 32,
    parameter int DATA_WD   = 64,
    parameter int TAG_WD    = 5,
    parameter int REQ_DEPTH = 4,
    parameter int MAX_OUT   = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    input  logic                 i_es_req_valid,
    output logic                 o_es_req_allowin,
    input  logic                 i_es_req_wr,
    input  logic [2:0]           i_es_req_mem_op,
    input  logic [ADDR_WD-1:0]   i_es_req_addr,
    input  logic [DATA_WD-1:0]   i_es_req_wdata,
    input  logic [TAG_WD-1:0]    i_es_req_tag,
    output logic                 o_data_sram_req,
    output logic                 o_data_sram_op,
    output logic [1:0]           o_data_sram_size,
    output logic [ADDR_WD-1:0]   o_data_sram_addr,
    output logic [DATA_WD/8-1:0] o_data_sram_wstrb,
    output logic [DATA_WD-1:0]   o_data_sram_wdata,
    input  logic                 i_data_sram_addr_ok,
    input  logic                 i_data_sram_data_ok,
    input  logic [DATA_WD-1:0]   i_data_sram_rdata,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [TAG_WD-1:0]    o_rsp_tag,
    output logic                 o_rsp_wr,
    output logic [DATA_WD-1:0]   o_rsp_rdata,
    output logic                 o_rsp_err,
    output logic                 o_busy
);
    localparam int STRB_WD = DATA_WD / 8;
    localparam int OFF_WD  = $clog2(STRB_WD);
    localparam int RQ_PW   = $clog2(REQ_DEPTH);
    localparam int RQ_CW   = RQ_PW + 1;
    localparam int MO_PW   = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_WD  = $clog2(MAX_OUT) + 1;
    localparam int CR_WD   = CNT_WD + 1;
    localparam logic [CR_WD-1:0] CREDIT_MAX = CR_WD'(MAX_OUT);
    localparam logic [RQ_CW-1:0] RQ_FULL    = RQ_CW'(REQ_DEPTH);

    typedef struct packed {
        logic               wr;
        logic [1:0]         size;
        logic [ADDR_WD-1:0] addr;
        logic [DATA_WD-1:0] wdata;
        logic [TAG_WD-1:0]  tag;
        logic               err;
    } req_t;

    typedef struct packed {
        logic [TAG_WD-1:0] tag;
        logic              wr;
    } pend_t;

    typedef struct packed {
        logic [TAG_WD-1:0]  tag;
        logic               wr;
        logic [DATA_WD-1:0] rdata;
        logic               err;
    } rsp_t;

    req_t  rq_mem [REQ_DEPTH];
    pend_t pd_mem [MAX_OUT];
    rsp_t  rs_mem [MAX_OUT];

    logic [RQ_PW-1:0]  rq_wp, rq_rp;
    logic [RQ_CW-1:0]  rq_cnt;
    logic [MO_PW-1:0]  pd_wp, pd_rp, rs_wp, rs_rp;
    logic [CNT_WD-1:0] out_cnt, rsp_cnt, drop_cnt;

    req_t  enq_entry, rq_head;
    pend_t pd_head;
    rsp_t  rs_head, rsp_in;
    logic  misalign, credit_ok, can_go, issue, bus_fire, err_pop, rq_pop, enq;
    logic  drop_ack, cpl, rsp_push, rsp_pop;
    logic [STRB_WD-1:0] size_mask;
    logic [OFF_WD-1:0]  offset;

    function automatic logic [MO_PW-1:0] mo_inc(input logic [MO_PW-1:0] p);
        return (p == MO_PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        enq_entry.wr    = i_es_req_wr;
        enq_entry.size  = i_es_req_mem_op[2:1];
        enq_entry.addr  = i_es_req_addr;
        enq_entry.wdata = i_es_req_wdata;
        enq_entry.tag   = i_es_req_tag;
        case (i_es_req_mem_op[2:1])
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = i_es_req_addr[0];
            2'd2:    misalign = |i_es_req_addr[1:0];
            default: misalign = |i_es_req_addr[2:0];
        endcase
        enq_entry.err = misalign || (i_es_req_mem_op == 3'b111)
                     || ((i_es_req_mem_op[2:1] == 2'd3) && (DATA_WD == 32));
    end

    assign rq_head = rq_mem[rq_rp];
    assign pd_head = pd_mem[pd_rp];
    assign rs_head = rs_mem[rs_rp];

    assign o_es_req_allowin = (rq_cnt != RQ_FULL) && !i_flush;
    assign enq              = i_es_req_valid && o_es_req_allowin;

    // Issue is blocked while dropped transactions from a flush are still draining.
    assign credit_ok = ({1'b0, out_cnt} + {1'b0, rsp_cnt}) < CREDIT_MAX;
    assign can_go    = (rq_cnt != '0) && credit_ok && !i_flush && (drop_cnt == '0);
    assign issue     = can_go && !rq_head.err;
    assign bus_fire  = issue && i_data_sram_addr_ok;
    assign err_pop   = can_go && rq_head.err && (out_cnt == '0);
    assign rq_pop    = bus_fire || err_pop;

    assign drop_ack = i_data_sram_data_ok && (drop_cnt != '0);
    assign cpl      = i_data_sram_data_ok && (drop_cnt == '0) && (out_cnt != '0);
    assign rsp_push = (cpl && !i_flush) || err_pop;
    assign rsp_pop  = (rsp_cnt != '0) && i_rsp_ready && !i_flush;

    always_comb begin
        rsp_in.tag   = rq_head.tag;
        rsp_in.wr    = rq_head.wr;
        rsp_in.rdata = '0;
        rsp_in.err   = 1'b1;
        if (cpl) begin
            rsp_in.tag   = pd_head.tag;
            rsp_in.wr    = pd_head.wr;
            rsp_in.rdata = pd_head.wr ? '0 : i_data_sram_rdata;
            rsp_in.err   = 1'b0;
        end
    end

    always_comb begin
        size_mask = '0;
        for (int unsigned i = 0; i < STRB_WD; i++) begin
            if (i < (32'd1 << rq_head.size)) size_mask[i] = 1'b1;
        end
    end

    assign offset            = rq_head.addr[OFF_WD-1:0];
    assign o_data_sram_req   = issue;
    assign o_data_sram_op    = issue && rq_head.wr;
    assign o_data_sram_size  = issue ? rq_head.size : 2'd0;
    assign o_data_sram_addr  = issue ? rq_head.addr : '0;
    assign o_data_sram_wstrb = (issue && rq_head.wr) ? (size_mask << offset) : '0;
    assign o_data_sram_wdata = issue ? (rq_head.wdata << {offset, 3'b000}) : '0;

    assign o_rsp_valid = (rsp_cnt != '0);
    assign o_rsp_tag   = o_rsp_valid ? rs_head.tag : '0;
    assign o_rsp_wr    = o_rsp_valid && rs_head.wr;
    assign o_rsp_rdata = o_rsp_valid ? rs_head.rdata : '0;
    assign o_rsp_err   = o_rsp_valid && rs_head.err;
    assign o_busy      = (rq_cnt != '0) || (out_cnt != '0) || (rsp_cnt != '0) || (drop_cnt != '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rq_wp    <= '0;
            rq_rp    <= '0;
            rq_cnt   <= '0;
            pd_wp    <= '0;
            pd_rp    <= '0;
            rs_wp    <= '0;
            rs_rp    <= '0;
            rsp_cnt  <= '0;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else if (i_flush) begin
            rq_wp    <= '0;
            rq_rp    <= '0;
            rq_cnt   <= '0;
            pd_wp    <= '0;
            pd_rp    <= '0;
            rs_wp    <= '0;
            rs_rp    <= '0;
            rsp_cnt  <= '0;
            out_cnt  <= '0;
            // Outstanding beats become drops; a data_ok landing this cycle is already one of them.
            drop_cnt <= drop_cnt + out_cnt - CNT_WD'(cpl) - CNT_WD'(drop_ack);
        end else begin
            if (enq)      rq_wp <= rq_wp + 1'b1;
            if (rq_pop)   rq_rp <= rq_rp + 1'b1;
            rq_cnt <= rq_cnt + RQ_CW'(enq) - RQ_CW'(rq_pop);
            if (bus_fire) pd_wp <= mo_inc(pd_wp);
            if (cpl)      pd_rp <= mo_inc(pd_rp);
            out_cnt  <= out_cnt + CNT_WD'(bus_fire) - CNT_WD'(cpl);
            drop_cnt <= drop_cnt - CNT_WD'(drop_ack);
            if (rsp_push) rs_wp <= mo_inc(rs_wp);
            if (rsp_pop)  rs_rp <= mo_inc(rs_rp);
            rsp_cnt <= rsp_cnt + CNT_WD'(rsp_push) - CNT_WD'(rsp_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (enq)      rq_mem[rq_wp] <= enq_entry;
        if (bus_fire) pd_mem[pd_wp] <= '{tag: rq_head.tag, wr: rq_head.wr};
        if (rsp_push) rs_mem[rs_wp] <= rsp_in;
    end
endmodule
